// File: rtl/sim_ac_pkg.sv
// Shared definitions for the Sim-AC accumulator CPU: opcodes and sequencer states.
// Pure definitions, no latency.
// No flow control; used by the control unit and the branch unit.
package sim_ac_pkg;

    localparam int OP_W_ISA = 3;

    typedef logic [OP_W_ISA-1:0] opcode_t;

    localparam opcode_t OP_NOP = 3'b000;
    localparam opcode_t OP_ADD = 3'b001;
    localparam opcode_t OP_LDA = 3'b010;
    localparam opcode_t OP_STA = 3'b011;
    localparam opcode_t OP_JMP = 3'b100;
    localparam opcode_t OP_JZ  = 3'b101;
    localparam opcode_t OP_JC  = 3'b110;
    localparam opcode_t OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_FETCH1 = 3'd2,
        ST_DECODE = 3'd3,
        ST_EXEC0  = 3'd4,
        ST_EXEC1  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // Instructions that need a second RAM access through the IR operand.
    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_ADD) || (op == OP_LDA) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the Sim-AC datapath strobes.
// NOP 3 cycles, JMP/JZ/JC 4, LDA/ADD/STA 5, plus one cycle per memory wait state.
// Stalls in FETCH1/EXEC1 while mem_ready_i is low; load/increment strobes held off while stalled.
module control_unit
    import sim_ac_pkg::*;
#(
    parameter int OP_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic [OP_W-1:0]  ir_op_i,
    input  logic             mem_ready_i,
    input  logic             branch_i,
    output logic [OP_W-1:0]  op_o,
    output logic             ctrl_jmp_o,
    output logic             mar_sel_o,
    output logic             mar_load_o,
    output logic             ram_rd_o,
    output logic             ram_wr_o,
    output logic             ir_load_o,
    output logic             pc_inc_o,
    output logic             pc_load_o,
    output logic             acc_load_o,
    output logic             alu_add_o,
    output logic             flags_load_o,
    output logic             halt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    state_t            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    // Next state, strobe decode and retire detection from current state and inputs.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        retire       = 1'b0;
        ctrl_jmp_o   = 1'b0;
        mar_sel_o    = 1'b0;
        mar_load_o   = 1'b0;
        ram_rd_o     = 1'b0;
        ram_wr_o     = 1'b0;
        ir_load_o    = 1'b0;
        pc_inc_o     = 1'b0;
        pc_load_o    = 1'b0;
        acc_load_o   = 1'b0;
        alu_add_o    = 1'b0;
        flags_load_o = 1'b0;
        halt_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH0;
            end
            ST_FETCH0: begin
                mar_sel_o  = 1'b0;
                mar_load_o = 1'b1;
                state_d    = ST_FETCH1;
            end
            ST_FETCH1: begin
                ram_rd_o = 1'b1;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    pc_inc_o  = 1'b1;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                op_d = ir_op_i;
                if (ir_op_i == OP_HLT) begin
                    state_d = ST_HALT;
                end else if (ir_op_i == OP_NOP) begin
                    state_d = ST_FETCH0;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_EXEC0;
                end
            end
            ST_EXEC0: begin
                if (is_mem_op(op_q)) begin
                    mar_sel_o  = 1'b1;
                    mar_load_o = 1'b1;
                    state_d    = ST_EXEC1;
                end else begin
                    // Not-taken branches fall through: PC already advanced in FETCH1.
                    ctrl_jmp_o = 1'b1;
                    pc_load_o  = branch_i;
                    state_d    = ST_FETCH0;
                    retire     = 1'b1;
                end
            end
            ST_EXEC1: begin
                if (op_q == OP_STA) ram_wr_o = 1'b1;
                else                ram_rd_o = 1'b1;
                if (mem_ready_i) begin
                    if (op_q != OP_STA) begin
                        acc_load_o   = 1'b1;
                        flags_load_o = 1'b1;
                        alu_add_o    = (op_q == OP_ADD);
                    end
                    state_d = ST_FETCH0;
                    retire  = 1'b1;
                end
            end
            ST_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction count saturates rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    // State register, opcode latch and counter; reset abandons any in-flight access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign op_o        = op_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle sequencer for the Sim-AC 3-bit-opcode accumulator CPU.
- Steps every instruction through fetch/decode/execute and drives the datapath strobes.
- Upstream of the branch unit: supplies ctrl_jmp_o and the latched opcode, and takes branch_i back to drive the PC load.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- OP_W, 3, opcode width (fixed ISA; other values unsupported).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- run_i  in  1  leaves IDLE when 1.
- ir_op_i  in  OP_W  opcode field of instruction register (valid from DECODE).
- mem_ready_i  in  1  RAM access completes this cycle.
- branch_i  in  1  branch unit decision.
- op_o  out  OP_W  opcode latched in DECODE, to branch unit.
- ctrl_jmp_o  out  1  jump-qualify strobe to branch unit.
- mar_sel_o  out  1  MAR source: 0=PC, 1=IR operand.
- mar_load_o  out  1  load MAR.
- ram_rd_o  out  1  RAM read request.
- ram_wr_o  out  1  RAM write request.
- ir_load_o  out  1  load IR.
- pc_inc_o  out  1  PC increment.
- pc_load_o  out  1  PC load from operand.
- acc_load_o  out  1  load accumulator.
- alu_add_o  out  1  accumulator source = ALU sum (else RAM data).
- flags_load_o  out  1  update Z/C.
- halt_o  out  1  in HALT.
- instr_cnt_o  out  CNT_W  retired instructions.

Behaviour:
- Opcodes: 000 NOP, 001 ADD, 010 LDA, 011 STA, 100 JMP, 101 JZ, 110 JC, 111 HLT.
- Reset (asynchronous, immediate, also mid-instruction):
  - state=IDLE, op_o=0, instr_cnt_o=0, every strobe 0.
  - An in-flight RAM request is abandoned.
- States: IDLE, FETCH0, FETCH1, DECODE, EXEC0, EXEC1, HALT. Strobes are decoded combinationally from state and inputs.
- IDLE: all strobes 0; run_i=1 -> FETCH0.
- FETCH0: mar_sel_o=0, mar_load_o=1 -> FETCH1.
- FETCH1: ram_rd_o=1.
  - While mem_ready_i=0, stay; ir_load_o and pc_inc_o stay 0.
  - On mem_ready_i=1: ir_load_o=1, pc_inc_o=1 (single-cycle pulses) -> DECODE.
- DECODE: op_o<=ir_op_i.
  - 111 -> HALT.
  - 000 -> FETCH0, retire.
  - Others -> EXEC0.
- EXEC0:
  - ADD/LDA/STA: mar_sel_o=1, mar_load_o=1 -> EXEC1.
  - JMP/JZ/JC: ctrl_jmp_o=1, pc_load_o=branch_i (same cycle) -> FETCH0, retire. A not-taken branch simply falls through; PC was already incremented in FETCH1.
- EXEC1, LDA: ram_rd_o=1; stall on mem_ready_i=0; on ready: acc_load_o=1, flags_load_o=1 -> FETCH0, retire.
- EXEC1, ADD: ram_rd_o=1; stall on mem_ready_i=0; on ready: alu_add_o=1, acc_load_o=1, flags_load_o=1 -> FETCH0, retire.
- EXEC1, STA: ram_wr_o=1; stall on mem_ready_i=0; completes on ready -> FETCH0, retire.
- HALT: halt_o=1, all other strobes 0; exit only by reset. HLT is not counted.
- Retire: instr_cnt_o increments by 1 on the transition out of the last state; saturates at all-ones.
- Latency with zero wait states:
  - NOP 3 cycles; JMP/JZ/JC 4 cycles; LDA/ADD/STA 5 cycles.
  - Each memory wait cycle adds 1.
- ram_rd_o and ram_wr_o are never both 1.
- mar_load_o, ir_load_o, pc_inc_o, pc_load_o and acc_load_o are never asserted in a stall cycle.
- run_i is sampled only in IDLE.

Decomposition:
- Shared package sim_ac_pkg: opcode localparams (OP_NOP…OP_HLT) and the state enumeration constants; the branch unit reuses the same opcode constants.
- No sub-module; a single module with the state register, op latch and counter.

Test Plan:
- Reset then run_i=1, ir_op_i=010, mem_ready_i=1 -> states IDLE,F0,F1,DEC,E0,E1,F0; acc_load_o pulses 1 cycle in E1; instr_cnt_o=1 after 6 cycles.
- JZ (101) with branch_i=1 -> ctrl_jmp_o=1 and pc_load_o=1 in E0, op_o=101; repeat with branch_i=0 -> ctrl_jmp_o=1, pc_load_o=0; instr_cnt_o increments both times.
- ADD with mem_ready_i=0 for 3 cycles in FETCH1 and 2 cycles in EXEC1 -> state holds, no ir_load/pc_inc/acc_load during stalls; total 10 cycles; alu_add_o=1 only in ready cycle.
- STA -> ram_wr_o=1 in E1, ram_rd_o=0 throughout E1; acc_load_o never 1.
- HLT -> halt_o=1 from cycle after DECODE and held 20 cycles; instr_cnt_o unchanged; run_i toggling has no effect.
- rst_i asserted asynchronously mid-EXEC1 stall -> all strobes 0 and instr_cnt_o=0 before next clock edge; restarts in IDLE.
